// File: rtl/candidate_sequencer.sv
// Command sequencer for the candidate popcount accumulator: walks every row of up to
// three MapCell maps per command and hands the final candidate over a done handshake.
module candidate_sequencer #(
  parameter int ROWS   = 8,
  parameter int ROW_AW = 3,
  parameter int MAP_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [MAP_AW-1:0] cmd_map_a,
  input  logic [MAP_AW-1:0] cmd_map_b,
  input  logic [MAP_AW-1:0] cmd_map_c,
  input  logic              abort,
  output logic [MAP_AW-1:0] map_sel,
  output logic [ROW_AW-1:0] row_addr,
  output logic [1:0]        reg_mode,
  output logic [1:0]        count,
  output logic              Candidate_en,
  output logic              busy,
  output logic              done_valid,
  input  logic              done_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_reg, state_next;
  logic [1:0]          mode_reg, mode_next;
  logic [MAP_AW-1:0]   map_a_reg, map_a_next;
  logic [MAP_AW-1:0]   map_b_reg, map_b_next;
  logic [MAP_AW-1:0]   map_c_reg, map_c_next;
  logic [ROW_AW-1:0]   row_reg, row_next;
  logic [1:0]          phase_reg, phase_next;

  logic                cmd_ready_next;
  logic [MAP_AW-1:0]   map_sel_next;
  logic [ROW_AW-1:0]   row_addr_next;
  logic [1:0]          reg_mode_next;
  logic [1:0]          count_next;
  logic                candidate_en_next;
  logic                busy_next;
  logic                done_valid_next;

  // Highest phase of a row, i.e. number of operands minus one.
  function automatic logic [1:0] last_phase(input logic [1:0] mode);
    case (mode)
      2'd0:    return 2'd0;
      2'd3:    return 2'd2;
      default: return 2'd1;
    endcase
  endfunction

  // The operand fetched in phase 0 is the one the accumulator combines with history.
  function automatic logic [MAP_AW-1:0] pick_map(
    input logic [1:0]        mode,
    input logic [1:0]        phase,
    input logic [MAP_AW-1:0] a,
    input logic [MAP_AW-1:0] b,
    input logic [MAP_AW-1:0] c
  );
    case (phase)
      2'd2:    return a;
      2'd1:    return (mode == 2'd3) ? b : a;
      default: begin
        case (mode)
          2'd0:    return a;
          2'd3:    return c;
          default: return b;
        endcase
      end
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    mode_next  = mode_reg;
    map_a_next = map_a_reg;
    map_b_next = map_b_reg;
    map_c_next = map_c_reg;
    row_next   = row_reg;
    phase_next = phase_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          state_next = RUN;
          mode_next  = cmd_mode;
          map_a_next = cmd_map_a;
          map_b_next = cmd_map_b;
          map_c_next = cmd_map_c;
          row_next   = '0;
          phase_next = last_phase(cmd_mode);
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (phase_reg == 2'd0) begin
          if (row_reg == ROW_AW'(ROWS - 1)) begin
            state_next = DONE;
          end else begin
            row_next   = row_reg + ROW_AW'(1);
            phase_next = last_phase(mode_reg);
          end
        end else begin
          phase_next = phase_reg - 2'd1;
        end
      end
      DONE: begin
        if (abort || done_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are derived from the next state so they are registered yet cycle-aligned.
  always_comb begin
    cmd_ready_next    = 1'b0;
    map_sel_next      = '0;
    row_addr_next     = '0;
    reg_mode_next     = 2'd0;
    count_next        = 2'd0;
    candidate_en_next = 1'b0;
    busy_next         = 1'b0;
    done_valid_next   = 1'b0;

    case (state_next)
      RUN: begin
        candidate_en_next = 1'b1;
        busy_next         = 1'b1;
        reg_mode_next     = mode_next;
        count_next        = phase_next;
        row_addr_next     = row_next;
        map_sel_next      = pick_map(mode_next, phase_next, map_a_next, map_b_next, map_c_next);
      end
      DONE: begin
        candidate_en_next = 1'b1;
        busy_next         = 1'b1;
        done_valid_next   = 1'b1;
        reg_mode_next     = 2'b01;
        count_next        = 2'd1;
      end
      default: cmd_ready_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      mode_reg     <= 2'd0;
      map_a_reg    <= '0;
      map_b_reg    <= '0;
      map_c_reg    <= '0;
      row_reg      <= '0;
      phase_reg    <= 2'd0;
      cmd_ready    <= 1'b1;
      map_sel      <= '0;
      row_addr     <= '0;
      reg_mode     <= 2'd0;
      count        <= 2'd0;
      Candidate_en <= 1'b0;
      busy         <= 1'b0;
      done_valid   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      mode_reg     <= mode_next;
      map_a_reg    <= map_a_next;
      map_b_reg    <= map_b_next;
      map_c_reg    <= map_c_next;
      row_reg      <= row_next;
      phase_reg    <= phase_next;
      cmd_ready    <= cmd_ready_next;
      map_sel      <= map_sel_next;
      row_addr     <= row_addr_next;
      reg_mode     <= reg_mode_next;
      count        <= count_next;
      Candidate_en <= candidate_en_next;
      busy         <= busy_next;
      done_valid   <= done_valid_next;
    end
  end

endmodule

// File: tb/tb_candidate_sequencer.sv
// Directed bench: models MapCell rows and the popcount accumulator around the sequencer.
module tb_candidate_sequencer;
  localparam int ROWS = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [2:0] cmd_map_a, cmd_map_b, cmd_map_c;
  logic       abort;
  logic [2:0] map_sel;
  logic [2:0] row_addr;
  logic [1:0] reg_mode;
  logic [1:0] count;
  logic       Candidate_en;
  logic       busy;
  logic       done_valid;
  logic       done_ready;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [8][8];
  logic [7:0] row_data;
  logic [7:0] cand, h1, h2;

  localparam logic [13:0] IDLE_V = {4'b1000, 10'd0};
  localparam logic [13:0] DONE_V = {4'b0111, 2'b01, 2'b01, 6'd0};

  candidate_sequencer #(.ROWS(ROWS), .ROW_AW(3), .MAP_AW(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_map_a(cmd_map_a), .cmd_map_b(cmd_map_b),
    .cmd_map_c(cmd_map_c), .abort(abort), .map_sel(map_sel), .row_addr(row_addr),
    .reg_mode(reg_mode), .count(count), .Candidate_en(Candidate_en), .busy(busy),
    .done_valid(done_valid), .done_ready(done_ready)
  );

  always #5 clk = ~clk;

  assign row_data = mem[map_sel][row_addr];

  // Accumulator model: history captured while count!=0, combined when count==0.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cand <= 8'd0; h1 <= 8'd0; h2 <= 8'd0;
    end else if (!Candidate_en) begin
      cand <= 8'd0; h1 <= 8'd0; h2 <= 8'd0;
    end else if (reg_mode == 2'd0) begin
      cand <= cand + 8'($countones(row_data));
    end else if (count == 2'd0) begin
      case (reg_mode)
        2'd1:    cand <= cand + 8'($countones(h1 & row_data));
        2'd2:    cand <= cand + 8'($countones(h1 ^ row_data));
        default: cand <= cand + 8'($countones((h2 & h1 & ~row_data) |
                                               (h2 & ~h1 & row_data) |
                                               (~h2 & h1 & row_data)));
      endcase
    end else if (count == 2'd1) begin
      h1 <= row_data;
    end else begin
      h2 <= row_data;
    end
  end

  function automatic logic [13:0] outs();
    return {cmd_ready, busy, done_valid, Candidate_en, reg_mode, count, map_sel, row_addr};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_cmd(input logic [1:0] mode, input logic [2:0] a, input logic [2:0] b,
                         input logic [2:0] c, input int hold, input logic [7:0] exp_cand,
                         input logic abort_at_accept);
    int ops;
    logic [2:0] mp [3];
    logic [1:0] ph [3];
    case (mode)
      2'd0: begin ops = 1; mp[0] = a; ph[0] = 2'd0; end
      2'd3: begin ops = 3; mp[0] = a; mp[1] = b; mp[2] = c;
                  ph[0] = 2'd2; ph[1] = 2'd1; ph[2] = 2'd0; end
      default: begin ops = 2; mp[0] = a; mp[1] = b; ph[0] = 2'd1; ph[1] = 2'd0; end
    endcase
    cmd_valid = 1'b1; cmd_mode = mode; cmd_map_a = a; cmd_map_b = b; cmd_map_c = c;
    abort = abort_at_accept;
    step();
    cmd_valid = 1'b0; abort = 1'b0;
    for (int i = 0; i < ROWS * ops; i++) begin
      check($sformatf("run_m%0d_c%0d", mode, i), 32'(outs()),
            32'({4'b0101, mode, ph[i % ops], mp[i % ops], 3'(i / ops)}));
      step();
    end
    check($sformatf("done_m%0d", mode), 32'(outs()), 32'(DONE_V));
    check($sformatf("cand_m%0d", mode), 32'(cand), 32'(exp_cand));
    for (int h = 0; h < hold; h++) begin
      step();
      check($sformatf("hold_m%0d_%0d", mode, h), 32'(outs()), 32'(DONE_V));
      check($sformatf("hold_cand_m%0d_%0d", mode, h), 32'(cand), 32'(exp_cand));
    end
    done_ready = 1'b1;
    step();
    done_ready = 1'b0;
    check($sformatf("idle_after_m%0d", mode), 32'(outs()), 32'(IDLE_V));
    check($sformatf("cand_kept_m%0d", mode), 32'(cand), 32'(exp_cand));
    step();
    check($sformatf("cand_clr_m%0d", mode), 32'(cand), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int m = 0; m < 8; m++)
      for (int r = 0; r < 8; r++) mem[m][r] = 8'h00;
    for (int r = 0; r < 8; r++) begin
      mem[1][r] = 8'hFF; mem[2][r] = 8'hF0; mem[3][r] = 8'h0F;
      mem[4][r] = 8'h00; mem[5][r] = 8'hAA; mem[6][r] = 8'h55;
    end
    rst = 1'b1; cmd_valid = 1'b0; cmd_mode = 2'd0; abort = 1'b0; done_ready = 1'b0;
    cmd_map_a = 3'd0; cmd_map_b = 3'd0; cmd_map_c = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'(outs()), 32'(IDLE_V));
    rst = 1'b0;
    step();
    check("idle_outs", 32'(outs()), 32'(IDLE_V));

    // 1: mode 0 popcount of all-ones map
    run_cmd(2'd0, 3'd1, 3'd0, 3'd0, 0, 8'd64, 1'b0);
    // 2: mode 1, F0 & FF
    run_cmd(2'd1, 3'd2, 3'd1, 3'd0, 0, 8'd32, 1'b0);
    // 3: mode 3, exactly two of FF, 0F, 00
    run_cmd(2'd3, 3'd1, 3'd3, 3'd4, 0, 8'd32, 1'b0);
    // 4: mode 2, AA ^ 55 with done_ready held low
    run_cmd(2'd2, 3'd5, 3'd6, 3'd0, 5, 8'd64, 1'b0);

    // 5: abort at row 3 of a mode 0 command
    cmd_valid = 1'b1; cmd_mode = 2'd0; cmd_map_a = 3'd1;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    check("abort_row3", 32'(outs()), 32'({4'b0101, 2'd0, 2'd0, 3'd1, 3'd3}));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_idle", 32'(outs()), 32'(IDLE_V));
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("abort_no_done_%0d", k), 32'(outs()), 32'(IDLE_V));
    end
    check("abort_cand_clr", 32'(cand), 32'd0);
    run_cmd(2'd0, 3'd1, 3'd0, 3'd0, 0, 8'd64, 1'b1);

    // 6: asynchronous reset mid-RUN in mode 3
    cmd_valid = 1'b1; cmd_mode = 2'd3; cmd_map_a = 3'd1; cmd_map_b = 3'd3; cmd_map_c = 3'd4;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_outs", 32'(outs()), 32'(IDLE_V));
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_cand", 32'(cand), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", 32'(outs()), 32'(IDLE_V));
    run_cmd(2'd0, 3'd3, 3'd0, 3'd0, 1, 8'd32, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
